axis_video_pattern_gen: RTL and testbench

//  AXI4-Stream video source (master) for the vga_controller slave port s_axis_*.

---
 rtl/vga_pkg.sv | 64 ++++++
 rtl/axis_video_pattern_gen_raster.sv | 61 ++++++
 rtl/axis_video_pattern_gen.sv | 150 +++++++++++++++
 tb/tb_axis_video_pattern_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA types: pixel format, pattern select, timing-mode lookups and
// the colour-bar palette used by the AXIS pattern generator.
package vga_pkg;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_GRID  = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    VGA_640X480  = 2'd0,
    VGA_800X600  = 2'd1,
    VGA_1024X768 = 2'd2
  } VGA_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } patgen_state_e;

  localparam rgb565_t C_WHITE   = 16'hFFFF;
  localparam rgb565_t C_YELLOW  = 16'hFFE0;
  localparam rgb565_t C_CYAN    = 16'h07FF;
  localparam rgb565_t C_GREEN   = 16'h07E0;
  localparam rgb565_t C_MAGENTA = 16'hF81F;
  localparam rgb565_t C_RED     = 16'hF800;
  localparam rgb565_t C_BLUE    = 16'h001F;
  localparam rgb565_t C_BLACK   = 16'h0000;

  function automatic int get_hactive(VGA_mode_e m);
    case (m)
      VGA_640X480: return 640;
      VGA_800X600: return 800;
      default:     return 1024;
    endcase
  endfunction

  function automatic int get_vactive(VGA_mode_e m);
    case (m)
      VGA_640X480: return 480;
      VGA_800X600: return 600;
      default:     return 768;
    endcase
  endfunction

  // Bar index 0..7, left to right
  function automatic rgb565_t bar_color(logic [2:0] b);
    case (b)
      3'd0:    return C_WHITE;
      3'd1:    return C_YELLOW;
      3'd2:    return C_CYAN;
      3'd3:    return C_GREEN;
      3'd4:    return C_MAGENTA;
      3'd5:    return C_RED;
      3'd6:    return C_BLUE;
      default: return C_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/axis_video_pattern_gen_raster.sv
// patgen_raster_cnt: raster position of the next beat to be loaded.
// x/y walk the frame in raster order; bar/width counters track the colour
// bar without a divider. eol/eof describe the current (x,y).
module patgen_raster_cnt
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int XW       = $clog2(H_ACTIVE),
  parameter int YW       = $clog2(V_ACTIVE)
) (
  input  logic          pixel_clk,
  input  logic          pix_rstn_sync,
  input  logic          advance_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic [2:0]    bar_o,
  output logic          eol_o,
  output logic          eof_o
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int WW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [2:0]    bar_q;
  logic [WW-1:0] wcnt_q;

  assign eol_o = (x_q == XW'(H_ACTIVE - 1));
  assign eof_o = eol_o && (y_q == YW'(V_ACTIVE - 1));
  assign x_o   = x_q;
  assign y_o   = y_q;
  assign bar_o = bar_q;

  // Step one pixel per advance; wrap line and frame, restart bars each line
  always_ff @(posedge pixel_clk or negedge pix_rstn_sync) begin
    if (!pix_rstn_sync) begin
      x_q    <= '0;
      y_q    <= '0;
      bar_q  <= '0;
      wcnt_q <= '0;
    end else if (advance_i) begin
      if (eol_o) begin
        x_q    <= '0;
        bar_q  <= '0;
        wcnt_q <= '0;
        y_q    <= eof_o ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
        if (wcnt_q == WW'(BAR_W - 1)) begin
          wcnt_q <= '0;
          bar_q  <= bar_q + 3'd1;
        end else begin
          wcnt_q <= wcnt_q + WW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream RGB565 test-pattern source. One output register holds the
// current beat; the raster counter always points at the next beat to load.
// Optional per-frame XOR checksum: define PATGEN_CKSUM_EN.
module axis_video_pattern_gen
  import vga_pkg::*;
#(
  parameter VGA_mode_e MODE     = VGA_1024X768,
  parameter int        H_ACTIVE = get_hactive(MODE),
  parameter int        V_ACTIVE = get_vactive(MODE),
  parameter int        DATA_W   = 16
) (
  input  logic        pixel_clk,
  input  logic        pix_rstn_sync,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] frame_cnt,
  output logic        frame_done,
  output logic [15:0] frame_cksum
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  patgen_state_e state_q;
  logic          tvalid_q, tuser_q, tlast_q, eof_q, frame_done_q;
  rgb565_t       tdata_q;
  pattern_e      pat_q, pat_cur;
  logic [15:0]   frame_cnt_q;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [2:0]    bar;
  logic          eol, eof, first, hs, frame_hs, load;
  rgb565_t       pix;
  logic [7:0]    x8;
  logic [5:0]    y6;

  // Last beat only ends the stream when enable is low at that moment;
  // otherwise (0,0) of the next frame is loaded on the same edge.
  assign hs       = tvalid_q & m_axis_tready;
  assign frame_hs = hs & eof_q;
  assign load     = (state_q == ST_STREAM) & (~tvalid_q | (hs & ~(eof_q & ~enable)));
  assign first    = (x == '0) && (y == '0);
  assign pat_cur  = first ? pattern_e'(pattern_sel) : pat_q;

  patgen_raster_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_raster (
    .pixel_clk     (pixel_clk),
    .pix_rstn_sync (pix_rstn_sync),
    .advance_i     (load),
    .x_o           (x),
    .y_o           (y),
    .bar_o         (bar),
    .eol_o         (eol),
    .eof_o         (eof)
  );

  // Pattern value for the beat at the raster counter
  always_comb begin
    x8  = 8'(x);
    y6  = 6'(y);
    pix = C_BLACK;
    unique case (pat_cur)
      PAT_BARS:  pix = bar_color(bar);
      PAT_RAMP:  pix = {x8[7:3], x8[7:2], x8[7:3]};
      PAT_CHECK: pix = (x8[5] ^ y6[5]) ? C_WHITE : C_BLACK;
      default:   pix = ((x8[5:0] == 6'd0) || (y6 == 6'd0) || eol ||
                        (y == YW'(V_ACTIVE - 1))) ? C_WHITE : C_BLUE;
    endcase
  end

  // Control FSM and AXIS output register; beat held while stalled
  always_ff @(posedge pixel_clk or negedge pix_rstn_sync) begin
    if (!pix_rstn_sync) begin
      state_q      <= ST_IDLE;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
      eof_q        <= 1'b0;
      pat_q        <= PAT_BARS;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (enable) state_q <= ST_STREAM;
        ST_STREAM: begin
          if (load) begin
            tvalid_q <= 1'b1;
            tdata_q  <= pix;
            tuser_q  <= first;
            tlast_q  <= eol;
            eof_q    <= eof;
            if (first) pat_q <= pattern_e'(pattern_sel);
          end
          if (frame_hs) begin
            frame_cnt_q  <= frame_cnt_q + 16'd1;
            frame_done_q <= 1'b1;
            if (!enable) begin
              state_q  <= ST_IDLE;
              tvalid_q <= 1'b0;
              tuser_q  <= 1'b0;
              tlast_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PATGEN_CKSUM_EN
  rgb565_t run_q, cksum_q;

  // Running XOR of accepted beats; published and cleared on the last beat
  always_ff @(posedge pixel_clk or negedge pix_rstn_sync) begin
    if (!pix_rstn_sync) begin
      run_q   <= '0;
      cksum_q <= '0;
    end else if (hs) begin
      if (eof_q) begin
        cksum_q <= run_q ^ tdata_q;
        run_q   <= '0;
      end else begin
        run_q <= run_q ^ tdata_q;
      end
    end
  end

  assign frame_cksum = cksum_q;
`else
  assign frame_cksum = 16'h0000;
`endif

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign frame_cnt     = frame_cnt_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Directed bench for axis_video_pattern_gen at 16x4. Pixel values come from
// an independent pattern model; checksum expectation depends on PATGEN_CKSUM_EN.
module tb_axis_video_pattern_gen;

  localparam int H = 16;
  localparam int V = 4;
  localparam int N = H * V;

  logic        pixel_clk = 1'b0;
  logic        pix_rstn_sync;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tuser, m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [15:0] frame_cnt;
  logic        frame_done;
  logic [15:0] frame_cksum;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  axis_video_pattern_gen #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .pixel_clk     (pixel_clk),
    .pix_rstn_sync (pix_rstn_sync),
    .enable        (enable),
    .pattern_sel   (pattern_sel),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .frame_cnt     (frame_cnt),
    .frame_done    (frame_done),
    .frame_cksum   (frame_cksum)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) if (frame_done) done_seen <= done_seen + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pattern model
  function automatic logic [15:0] model(input int pat, input int x, input int y);
    int xi, yi, b;
    xi = x;
    yi = y;
    case (pat)
      0: begin
        b = x / (H / 8);
        case (b)
          0: return 16'hFFFF;  1: return 16'hFFE0;
          2: return 16'h07FF;  3: return 16'h07E0;
          4: return 16'hF81F;  5: return 16'hF800;
          6: return 16'h001F;  default: return 16'h0000;
        endcase
      end
      1: return {xi[7:3], xi[7:2], xi[7:3]};
      2: return (xi[5] ^ yi[5]) ? 16'hFFFF : 16'h0000;
      default: return ((xi[5:0] == 0) || (yi[5:0] == 0) || (x == H-1) || (y == V-1))
                      ? 16'hFFFF : 16'h001F;
    endcase
  endfunction

  task automatic do_reset();
    pix_rstn_sync = 1'b0;
    enable        = 1'b0;
    pattern_sel   = 2'd0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge pixel_clk);
    pix_rstn_sync = 1'b1;
  endtask

  // Collect one frame, checking every accepted beat and hold-while-stalled.
  // lead: up to the first beat, tvalid=0 cycles are allowed (exactly 1 expected).
  task automatic run_frame(input int pat, input bit rnd, input bit lead,
                           input int chg_at, input int chg_sel, input int drop_at);
    int idx, cyc, lead_cnt;
    bit stall;
    logic [15:0] pd;
    logic pu, pl;
    idx = 0; cyc = 0; lead_cnt = 0; stall = 0;
    pd = '0; pu = 0; pl = 0;
    while (idx < N && cyc < 2000) begin
      @(negedge pixel_clk);
      cyc++;
      if (idx == chg_at) pattern_sel = 2'(chg_sel);
      if (idx == drop_at) enable = 1'b0;
      if (stall) begin
        check("hold_valid", m_axis_tvalid, 1'b1);
        check("hold_data", m_axis_tdata, pd);
        check("hold_user", m_axis_tuser, pu);
        check("hold_last", m_axis_tlast, pl);
      end
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!m_axis_tvalid) begin
        if (lead && idx == 0) lead_cnt++;
        else check("gap", m_axis_tvalid, 1'b1);
      end else if (m_axis_tready) begin
        check($sformatf("pix%0d", idx), m_axis_tdata, model(pat, idx % H, idx / H));
        check($sformatf("user%0d", idx), m_axis_tuser, (idx == 0));
        check($sformatf("last%0d", idx), m_axis_tlast, ((idx % H) == H-1));
        idx++;
      end
      stall = m_axis_tvalid & ~m_axis_tready;
      pd = m_axis_tdata; pu = m_axis_tuser; pl = m_axis_tlast;
    end
    check("frame_beats", idx, N);
    if (lead) check("start_latency", lead_cnt, 1);
    m_axis_tready = 1'b1;
  endtask

  initial begin
    int base, cnt;
    logic [15:0] exp_ck;

    // 1: idle after reset
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge pixel_clk);
      check("idle_valid", m_axis_tvalid, 1'b0);
    end
    check("rst_data", m_axis_tdata, 16'h0);
    check("rst_user", m_axis_tuser, 1'b0);
    check("rst_last", m_axis_tlast, 1'b0);
    check("rst_cnt", frame_cnt, 16'h0);
    check("rst_done", frame_done, 1'b0);
    check("rst_cksum", frame_cksum, 16'h0);

    // 2: BARS, single frame from an enable pulse
    do_reset();
    base = done_seen;
    pattern_sel = 2'd0;
    enable = 1'b1;
    run_frame(0, 1'b0, 1'b1, -1, 0, 0);
    @(negedge pixel_clk);
    check("bars_done", frame_done, 1'b1);
    check("bars_cnt", frame_cnt, 16'd1);
    check("bars_stop", m_axis_tvalid, 1'b0);
    @(negedge pixel_clk);
    check("bars_done_clr", frame_done, 1'b0);
    check("bars_done_once", done_seen - base, 1);

    // 3: CHECK with random backpressure
    do_reset();
    pattern_sel = 2'd2;
    enable = 1'b1;
    run_frame(2, 1'b1, 1'b1, -1, 0, 0);
    @(negedge pixel_clk);
    check("chk_cnt", frame_cnt, 16'd1);

    // 4: three back-to-back frames, pattern switched mid frame 1
    do_reset();
    base = done_seen;
    pattern_sel = 2'd0;
    enable = 1'b1;
    run_frame(0, 1'b0, 1'b1, -1, 0, -1);
    run_frame(0, 1'b0, 1'b0, 5, 2, -1);
    run_frame(2, 1'b0, 1'b0, -1, 0, 10);
    @(negedge pixel_clk);
    check("b2b_done", frame_done, 1'b1);
    check("b2b_cnt", frame_cnt, 16'd3);
    check("b2b_stop", m_axis_tvalid, 1'b0);
    @(negedge pixel_clk);
    check("b2b_done_n", done_seen - base, 3);

    // 5: reset mid-frame, then restart cleanly with RAMP
    do_reset();
    pattern_sel = 2'd3;
    enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 20; i++) begin
      @(negedge pixel_clk);
      if (m_axis_tvalid && m_axis_tready) cnt++;
    end
    check("mid_beats", cnt, 20);
    pix_rstn_sync = 1'b0;
    #1;
    check("mid_rst_valid", m_axis_tvalid, 1'b0);
    check("mid_rst_data", m_axis_tdata, 16'h0);
    check("mid_rst_user", m_axis_tuser, 1'b0);
    check("mid_rst_cnt", frame_cnt, 16'h0);
    @(negedge pixel_clk);
    pattern_sel = 2'd1;
    pix_rstn_sync = 1'b1;
    run_frame(1, 1'b0, 1'b1, -1, 0, 0);
    @(negedge pixel_clk);
    check("mid_cnt", frame_cnt, 16'd1);

    // 6: GRID checksum
    do_reset();
    exp_ck = '0;
`ifdef PATGEN_CKSUM_EN
    for (int i = 0; i < N; i++) exp_ck ^= model(3, i % H, i / H);
`endif
    pattern_sel = 2'd3;
    enable = 1'b1;
    run_frame(3, 1'b0, 1'b1, -1, 0, 0);
    check("cksum_before", frame_cksum, 16'h0);
    @(negedge pixel_clk);
    check("cksum_done", frame_done, 1'b1);
    check("cksum_val", frame_cksum, exp_ck);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
